exec_control_unit: RTL and testbench

Execute/control stage that sits directly downstream of the main memory block and closes the loop back into it. It consumes the currently executed instruction, its address, the memory data word and the fetch/execute phase flag, and produces the next PC, data address, store data and store strobe that the memory samples. It implements a 32-entry register file and a small RV32I subset, with one instruction retired per two-cycle fetch/execute pair.

---
 rtl/exec_control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_exec_control_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_control_unit.sv
// Execute/control stage for a small RV32I subset. Works against a memory
// that alternates fetch (E=0) and execute (E=1) cycles. It computes the next
// PC, data address, store data and store strobe, owns the 32-entry register
// file, and writes load data back on the fetch edge after an LW.
module exec_control_unit (
  input  logic        clk,
  input  logic        Reset,
  input  logic        E,
  input  logic [31:0] PC_out,
  input  logic [31:0] Iout,
  input  logic [31:0] Mout,
  output logic [31:0] Next_PC,
  output logic [31:0] data_addr_in,
  output logic [31:0] data_in,
  output logic        S,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    K_ILL, K_ADD, K_SUB, K_ADDI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_ECALL
  } kind_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Architectural state
  logic [31:0] regs_q [32];
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        pend_valid_q, pend_valid_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic [31:0] retired_q, retired_d;

  // Register-file write port
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] pc_plus4;
  logic [31:0] exec_next_pc, exec_addr;
  kind_e       kind;

  assign opcode = Iout[6:0];
  assign funct3 = Iout[14:12];
  assign funct7 = Iout[31:25];
  assign rd     = Iout[11:7];
  assign rs1    = Iout[19:15];
  assign rs2    = Iout[24:20];

  assign imm_i = {{20{Iout[31]}}, Iout[31:20]};
  assign imm_s = {{20{Iout[31]}}, Iout[31:25], Iout[11:7]};
  assign imm_b = {{19{Iout[31]}}, Iout[31], Iout[7], Iout[30:25], Iout[11:8], 1'b0};
  assign imm_j = {{11{Iout[31]}}, Iout[31], Iout[19:12], Iout[20], Iout[30:21], 1'b0};
  assign imm_u = {Iout[31:12], 12'd0};

  assign rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  assign pc_plus4 = PC_out + 32'd4;

  // Decode the instruction into one of the supported kinds
  always_comb begin
    kind = K_ILL;
    case (opcode)
      OP_REG: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      kind = K_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) kind = K_SUB;
      end
      OP_IMM:    if (funct3 == 3'b000) kind = K_ADDI;
      OP_LUI:    kind = K_LUI;
      OP_LOAD:   if (funct3 == 3'b010) kind = K_LW;
      OP_STORE:  if (funct3 == 3'b010) kind = K_SW;
      OP_BRANCH: begin
        if (funct3 == 3'b000)      kind = K_BEQ;
        else if (funct3 == 3'b001) kind = K_BNE;
      end
      OP_JAL:    kind = K_JAL;
      OP_SYSTEM: kind = K_ECALL;
      default:   kind = K_ILL;
    endcase
  end

  // Execute-cycle PC and data address; ECALL and the halted state park the PC
  always_comb begin
    exec_next_pc = pc_plus4;
    if (halted_q || kind == K_ECALL)              exec_next_pc = PC_out;
    else if (kind == K_JAL)                       exec_next_pc = PC_out + imm_j;
    else if (kind == K_BEQ && rs1_val == rs2_val) exec_next_pc = PC_out + imm_b;
    else if (kind == K_BNE && rs1_val != rs2_val) exec_next_pc = PC_out + imm_b;
    exec_addr = rs1_val + ((kind == K_SW) ? imm_s : imm_i);
  end

  // Next-state: retire on execute, complete pending load on fetch
  always_comb begin
    next_pc_d    = next_pc_q;
    addr_d       = addr_q;
    din_d        = din_q;
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    retired_d    = retired_q;
    rf_we        = 1'b0;
    rf_waddr     = rd;
    rf_wdata     = '0;
    if (E) begin
      next_pc_d = exec_next_pc;
      addr_d    = exec_addr;
      din_d     = rs2_val;
      if (!halted_q) begin
        retired_d = retired_q + 32'd1;
        case (kind)
          K_ADD:   begin rf_we = 1'b1; rf_wdata = rs1_val + rs2_val; end
          K_SUB:   begin rf_we = 1'b1; rf_wdata = rs1_val - rs2_val; end
          K_ADDI:  begin rf_we = 1'b1; rf_wdata = rs1_val + imm_i; end
          K_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
          K_JAL:   begin rf_we = 1'b1; rf_wdata = pc_plus4; end
          K_LW:    begin pend_valid_d = 1'b1; pend_rd_d = rd; end
          K_ECALL: halted_d = 1'b1;
          K_ILL:   illegal_d = 1'b1;
          default: ;
        endcase
      end
    end else if (pend_valid_q) begin
      rf_we        = 1'b1;
      rf_waddr     = pend_rd_q;
      rf_wdata     = Mout;
      pend_valid_d = 1'b0;
    end
  end

  // Outputs: reset forces zeros, fetch replays the last execute values
  always_comb begin
    Next_PC      = '0;
    data_addr_in = '0;
    data_in      = '0;
    S            = 1'b0;
    if (!Reset) begin
      if (E) begin
        Next_PC      = exec_next_pc;
        data_addr_in = exec_addr;
        data_in      = rs2_val;
        S            = (kind == K_SW) && !halted_q;
      end else begin
        Next_PC      = next_pc_q;
        data_addr_in = addr_q;
        data_in      = din_q;
      end
    end
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

  // Control/status registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      next_pc_q    <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      retired_q    <= '0;
    end else begin
      next_pc_q    <= next_pc_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      retired_q    <= retired_d;
    end
  end

  // Register file; x0 is never written
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i[4:0]] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_exec_control_unit.sv
// Bench for exec_control_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_exec_control_unit;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        E = 1'b0;
  logic [31:0] PC_out = '0;
  logic [31:0] Iout = '0;
  logic [31:0] Mout = '0;
  logic [31:0] Next_PC, data_addr_in, data_in, retired;
  logic        S, halted, illegal;

  int n_checks = 0;
  int n_fail = 0;

  exec_control_unit dut (
    .clk(clk), .Reset(Reset), .E(E), .PC_out(PC_out), .Iout(Iout), .Mout(Mout),
    .Next_PC(Next_PC), .data_addr_in(data_addr_in), .data_in(data_in), .S(S),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_npc, m_addr, m_din, m_retired;
  logic [4:0]  m_pend_rd;
  logic        m_pend, m_halted, m_illegal, m_valid = 1'b0;

  function automatic string classify(input logic [31:0] ins);
    logic [31:0] op, f3, f7;
    op = ins & 32'h7f;
    f3 = (ins >> 12) & 32'd7;
    f7 = ins >> 25;
    if (op == 32'h33 && f3 == 0 && f7 == 0)  return "ADD";
    if (op == 32'h33 && f3 == 0 && f7 == 32) return "SUB";
    if (op == 32'h13 && f3 == 0) return "ADDI";
    if (op == 32'h37) return "LUI";
    if (op == 32'h03 && f3 == 2) return "LW";
    if (op == 32'h23 && f3 == 2) return "SW";
    if (op == 32'h63 && f3 == 0) return "BEQ";
    if (op == 32'h63 && f3 == 1) return "BNE";
    if (op == 32'h6f) return "JAL";
    if (op == 32'h73) return "ECALL";
    return "ILL";
  endfunction

  function automatic logic [31:0] rreg(input logic [31:0] idx);
    logic [4:0] i;
    i = idx[4:0];
    return (i == 5'd0) ? 32'd0 : m_regs[i];
  endfunction

  // Compare DUT against the model each cycle, then advance the model for the next edge
  always @(negedge clk) begin : cmp
    logic [31:0] enpc, eaddr, edin, a, b, sx, ins, rdi;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, wval;
    logic        es, wr;
    string       k;
    ins = Iout;
    k = classify(ins);
    sx = ins[31] ? 32'hFFFF_FFFF : 32'd0;
    imm_i = (sx << 12) | (ins >> 20);
    imm_s = (sx << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'd31);
    imm_b = (sx << 12) | (((ins >> 7) & 32'd1) << 11) | (((ins >> 25) & 32'd63) << 5)
          | (((ins >> 8) & 32'd15) << 1);
    imm_j = (sx << 20) | (((ins >> 12) & 32'd255) << 12) | (((ins >> 20) & 32'd1) << 11)
          | (((ins >> 21) & 32'd1023) << 1);
    a = rreg((ins >> 15) & 32'd31);
    b = rreg((ins >> 20) & 32'd31);
    rdi = (ins >> 7) & 32'd31;
    enpc = 0; eaddr = 0; edin = 0; es = 0;
    if (!Reset && E) begin
      if (m_halted || k == "ECALL")        enpc = PC_out;
      else if (k == "JAL")                 enpc = PC_out + imm_j;
      else if (k == "BEQ" && a == b)       enpc = PC_out + imm_b;
      else if (k == "BNE" && a != b)       enpc = PC_out + imm_b;
      else                                 enpc = PC_out + 4;
      eaddr = a + ((k == "SW") ? imm_s : imm_i);
      edin = b;
      es = (k == "SW") && !m_halted;
    end else if (!Reset) begin
      enpc = m_npc; eaddr = m_addr; edin = m_din;
    end
    if (Reset || m_valid) begin
      check("Next_PC", Next_PC, enpc);
      check("data_addr_in", data_addr_in, eaddr);
      check("data_in", data_in, edin);
      check("S", {31'd0, S}, {31'd0, es});
    end
    if (m_valid) begin
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("illegal", {31'd0, illegal}, {31'd0, m_illegal});
      check("retired", retired, m_retired);
    end
    if (Reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_npc = 0; m_addr = 0; m_din = 0; m_retired = 0;
      m_pend = 0; m_pend_rd = 0; m_halted = 0; m_illegal = 0; m_valid = 1;
    end else if (m_valid && E) begin
      m_npc = enpc; m_addr = eaddr; m_din = edin;
      if (!m_halted) begin
        m_retired = m_retired + 1;
        wr = 1; wval = 0;
        case (k)
          "ADD":  wval = a + b;
          "SUB":  wval = a - b;
          "ADDI": wval = a + imm_i;
          "LUI":  wval = ins & 32'hFFFF_F000;
          "JAL":  wval = PC_out + 4;
          default: wr = 0;
        endcase
        if (wr && rdi != 0) m_regs[rdi[4:0]] = wval;
        if (k == "LW") begin m_pend = 1; m_pend_rd = rdi[4:0]; end
        if (k == "ECALL") m_halted = 1;
        if (k == "ILL") m_illegal = 1;
      end
    end else if (m_valid && m_pend) begin
      if (m_pend_rd != 0) m_regs[m_pend_rd] = Mout;
      m_pend = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic e, input logic [31:0] pc,
                      input logic [31:0] ins, input logic [31:0] mo);
    @(posedge clk);
    #1;
    Reset = r; E = e; PC_out = pc; Iout = ins; Mout = mo;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    int unsigned sel;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] r;
    sel = $urandom_range(0, 99);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    r   = $urandom;
    if (sel < 12) return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    if (sel < 22) return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
    if (sel < 34) return {r[11:0], rs1, 3'b000, rd, 7'b0010011};
    if (sel < 42) return {r[19:0], rd, 7'b0110111};
    if (sel < 54) return {r[11:0], rs1, 3'b010, rd, 7'b0000011};
    if (sel < 66) return {r[11:5], rs2, rs1, 3'b010, r[4:0], 7'b0100011};
    if (sel < 76) return {r[12], r[10:5], rs2, rs1, 3'b000, r[4:1], r[11], 7'b1100011};
    if (sel < 86) return {r[12], r[10:5], rs2, rs1, 3'b001, r[4:1], r[11], 7'b1100011};
    if (sel < 92) return {r[20], r[10:1], r[11], r[19:12], rd, 7'b1101111};
    if (sel < 94) return 32'h0000_0073;
    if (sel < 97) return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
    return r;
  endfunction

  initial begin
    logic        e_prev, e_now, rst;
    logic [31:0] pc;
    // Reset held two edges, released into a fetch cycle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_next_pc", Next_PC, 32'd0);
    check("rst_s", {31'd0, S}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired, 32'd0);
    // ADDI x1,x0,5
    step(0, 1, 32'h0, 32'h0050_0093, 0);
    check("addi_next_pc", Next_PC, 32'd4);
    step(0, 0, 32'h0, 32'h0050_0093, 0);
    check("addi_retired", retired, 32'd1);
    check("fetch_next_pc", Next_PC, 32'd4);
    // ADD x2,x1,x1
    step(0, 1, 32'h4, 32'h0010_8133, 0);
    step(0, 0, 32'h4, 32'h0010_8133, 0);
    // SW x1,8(x0)
    step(0, 1, 32'h8, 32'h0010_2423, 0);
    check("sw_s", {31'd0, S}, 32'd1);
    check("sw_addr", data_addr_in, 32'd8);
    check("sw_data", data_in, 32'd5);
    step(0, 0, 32'h8, 32'h0010_2423, 0);
    check("sw_fetch_s", {31'd0, S}, 32'd0);
    check("sw_fetch_addr", data_addr_in, 32'd8);
    // SW x2,12(x0) shows x2 = 10
    step(0, 1, 32'hC, 32'h0020_2623, 0);
    check("add_result", data_in, 32'd10);
    check("sw2_addr", data_addr_in, 32'd12);
    step(0, 0, 32'hC, 32'h0020_2623, 0);
    // LW x3,8(x0) then fetch with load data, then SW x3 to observe
    step(0, 1, 32'h10, 32'h0080_2183, 0);
    step(0, 0, 32'h10, 32'h0080_2183, 32'h0000_002A);
    step(0, 1, 32'h14, 32'h0030_2023, 0);
    check("lw_result", data_in, 32'h2A);
    step(0, 0, 32'h14, 32'h0030_2023, 0);
    // LW x0 discards the data
    step(0, 1, 32'h18, 32'h0080_2003, 0);
    step(0, 0, 32'h18, 32'h0080_2003, 32'h0000_0055);
    step(0, 1, 32'h1C, 32'h0000_2023, 0);
    check("lw_x0", data_in, 32'd0);
    step(0, 0, 32'h1C, 32'h0000_2023, 0);
    // Branches and JAL
    step(0, 1, 32'h20, 32'hFE10_8CE3, 0);
    check("beq_taken", Next_PC, 32'h18);
    step(0, 0, 32'h20, 32'hFE10_8CE3, 0);
    check("beq_fetch", Next_PC, 32'h18);
    step(0, 1, 32'h20, 32'hFE10_9CE3, 0);
    check("bne_not_taken", Next_PC, 32'h24);
    step(0, 0, 32'h20, 32'hFE10_9CE3, 0);
    step(0, 1, 32'h10, 32'h1000_02EF, 0);
    check("jal_target", Next_PC, 32'h110);
    step(0, 0, 32'h10, 32'h1000_02EF, 0);
    step(0, 1, 32'h110, 32'h0050_2023, 0);
    check("jal_link", data_in, 32'h14);
    step(0, 0, 32'h110, 32'h0050_2023, 0);
    check("model_x1", m_regs[1], 32'd5);
    check("model_x2", m_regs[2], 32'd10);
    check("model_x3", m_regs[3], 32'h2A);
    check("model_x5", m_regs[5], 32'h14);
    // ECALL at 0x40
    step(0, 1, 32'h40, 32'h0000_0073, 0);
    check("ecall_next_pc", Next_PC, 32'h40);
    step(0, 0, 32'h40, 32'h0000_0073, 0);
    check("ecall_halted", {31'd0, halted}, 32'd1);
    check("ecall_retired", retired, 32'd13);
    check("halt_fetch_pc", Next_PC, 32'h40);
    step(0, 1, 32'h40, 32'h0010_2423, 0);
    check("halt_no_store", {31'd0, S}, 32'd0);
    check("halt_exec_pc", Next_PC, 32'h40);
    step(0, 0, 32'h40, 32'h0010_2423, 0);
    check("halt_retired_frozen", retired, 32'd13);
    // Fresh run: illegal opcode
    step(1, 0, 0, 0, 0);
    check("reset_forced_pc", Next_PC, 32'd0);
    step(0, 1, 32'h0, 32'h0000_007F, 0);
    check("ill_next_pc", Next_PC, 32'd4);
    step(0, 0, 32'h0, 32'h0000_007F, 0);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_retired", retired, 32'd1);
    check("ill_not_halted", {31'd0, halted}, 32'd0);

    // Randomized traffic, mostly alternating phases with occasional repeated E=1
    e_prev = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 7) == 0);
      if (e_prev) e_now = ($urandom_range(0, 15) == 0);
      else        e_now = ($urandom_range(0, 15) != 0);
      pc = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(rst, e_now, pc, rand_instr(), $urandom);
      e_prev = e_now;
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
